// File: rtl/mdu_iter.sv
// mdu_iter - iterative multiply/divide unit for the EX stage.
//
// Ops: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
// Multiplies go through a MUL_STAGES-deep registered product pipeline.
// Accumulating ops add one ACC cycle. Divides use a radix-2 restoring
// divider that produces one quotient bit per cycle. All paths finish in
// FIX, which applies signs, registers result and pulses done.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         aborts the operation in flight (no done, result kept)
//   start         request, accepted only in IDLE and without flush
//   op            operation select (see above)
//   op1, op2      rs / rt operands (dividend / divisor for divides)
//   hilo_i        current {hi,lo}, accumulator input for MADD/MSUB class
//   busy          operation in flight
//   done          one-cycle pulse when result is valid
//   result        {hi,lo}; for divides hi=remainder, lo=quotient
//   div0          set with done when the divisor was zero
//
// Build option: define MDU_DIV_EARLY_OUT_EN to skip the leading zeros of
// the dividend magnitude (one extra setup cycle, WIDTH-lz iterations).
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  localparam int CMAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, FIX} state_t;
  state_t state;

  // Decode of the incoming op (only meaningful on the accept edge)
  logic in_signed, in_div, in_acc, in_sub;
  assign in_signed = ~op[0];
  assign in_div    = ~op[2] & op[1];
  assign in_acc    = op[2];
  assign in_sub    = op[2] & op[1];

  logic [WIDTH-1:0] op1_mag, op2_mag;
  assign op1_mag = (in_signed && op1[WIDTH-1]) ? -op1 : op1;
  assign op2_mag = (in_signed && op2[WIDTH-1]) ? -op2 : op2;

  // Captured operation context
  logic [WIDTH-1:0]   a_mag, b_mag, op1_raw;
  logic [2*WIDTH-1:0] hilo_reg, acc_reg;
  logic               neg_reg, rem_neg_reg, zero_div_reg;
  logic               is_div_reg, is_acc_reg, is_sub_reg;
  logic [CW-1:0]      cnt_reg;

  // Divider datapath
  logic [WIDTH-1:0] rem_reg, quo_reg;
  logic [WIDTH:0]   trial;
  assign trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, b_mag};

  // Multiplier pipeline: stage 0 forms the unsigned magnitude product,
  // later stages only delay it. Operands are held while busy, so the tail
  // stays valid for as long as MUL/ACC/FIX need it.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_STAGES; gi++) begin : g_pipe
      logic [2*WIDTH-1:0] q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q <= '0;
          else        q <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q <= '0;
          else        q <= g_pipe[gi-1].q;
        end
      end
    end
  endgenerate

  logic [2*WIDTH-1:0] prod_s;
  assign prod_s = neg_reg ? -g_pipe[MUL_STAGES-1].q : g_pipe[MUL_STAGES-1].q;

  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign quo_fix = neg_reg     ? -quo_reg : quo_reg;
  assign rem_fix = rem_neg_reg ? -rem_reg : rem_reg;

`ifdef MDU_DIV_EARLY_OUT_EN
  logic          first_reg;
  logic [CW-1:0] lz;
  // Leading zeros of the dividend magnitude; WIDTH when it is zero
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (quo_reg[i]) lz = CW'(WIDTH - 1 - i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      div0         <= 1'b0;
      result       <= '0;
      a_mag        <= '0;
      b_mag        <= '0;
      op1_raw      <= '0;
      hilo_reg     <= '0;
      acc_reg      <= '0;
      neg_reg      <= 1'b0;
      rem_neg_reg  <= 1'b0;
      zero_div_reg <= 1'b0;
      is_div_reg   <= 1'b0;
      is_acc_reg   <= 1'b0;
      is_sub_reg   <= 1'b0;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
`ifdef MDU_DIV_EARLY_OUT_EN
      first_reg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              a_mag        <= op1_mag;
              b_mag        <= op2_mag;
              op1_raw      <= op1;
              hilo_reg     <= hilo_i;
              neg_reg      <= in_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
              rem_neg_reg  <= in_signed & op1[WIDTH-1];
              zero_div_reg <= (op2 == '0);
              is_div_reg   <= in_div;
              is_acc_reg   <= in_acc;
              is_sub_reg   <= in_sub;
              rem_reg      <= '0;
              quo_reg      <= op1_mag;
              div0         <= 1'b0;
              busy         <= 1'b1;
              if (in_div) begin
                state   <= DIV;
                cnt_reg <= CW'(WIDTH);
`ifdef MDU_DIV_EARLY_OUT_EN
                first_reg <= 1'b1;
`endif
              end else begin
                state   <= MUL;
                cnt_reg <= CW'(MUL_STAGES);
              end
            end
          end
          MUL: begin
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) state <= is_acc_reg ? ACC : FIX;
          end
          ACC: begin
            acc_reg <= is_sub_reg ? hilo_reg - prod_s : hilo_reg + prod_s;
            state   <= FIX;
          end
          DIV: begin
`ifdef MDU_DIV_EARLY_OUT_EN
            // Setup cycle: skip the dividend's leading zeros, keep at least
            // one iteration so a zero dividend still passes through the loop.
            if (first_reg) begin
              first_reg <= 1'b0;
              quo_reg   <= quo_reg << lz;
              cnt_reg   <= (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
            end else
`endif
            begin
              if (!trial[WIDTH]) begin
                rem_reg <= trial[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
              end else begin
                rem_reg <= {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
              end
              cnt_reg <= cnt_reg - CW'(1);
              if (cnt_reg == CW'(1)) state <= FIX;
            end
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div_reg) begin
              // Zero divisor: fixed all-ones quotient, dividend passed as-is
              if (zero_div_reg) begin
                result <= {op1_raw, {WIDTH{1'b1}}};
                div0   <= 1'b1;
              end else begin
                result <= {rem_fix, quo_fix};
              end
            end else if (is_acc_reg) begin
              result <= acc_reg;
            end else begin
              result <= prod_s;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter - scoreboard bench for mdu_iter (WIDTH=32, MUL_STAGES=2).
// Expected {div0,result} and latency are queued when a start is driven and
// compared when done pulses. Honours MDU_DIV_EARLY_OUT_EN for divide latency.
module tb_mdu_iter;
  localparam int W = 32;
  localparam int S = 2;

  localparam logic [2:0] MULT  = 3'd0, MULTU = 3'd1, DIV  = 3'd2, DIVU  = 3'd3;
  localparam logic [2:0] MADD  = 3'd4, MSUBU = 3'd7;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  op1 = '0, op2 = '0;
  logic [2*W-1:0] hilo_i = '0;
  logic          busy, done, div0;
  logic [2*W-1:0] result;

  mdu_iter #(.WIDTH(W), .MUL_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
    .op1(op1), .op2(op2), .hilo_i(hilo_i),
    .busy(busy), .done(done), .result(result), .div0(div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        d0;
    int          lat;
    int          t0;
    logic [2:0]  op;
  } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0, done_cnt = 0;
  logic done_prev = 1'b0;
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model using native signed/unsigned arithmetic
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] h);
    longint da, db, q, r;
    logic [63:0] sp, up;
    da = longint'($signed(a));
    db = longint'($signed(b));
    sp = 64'(da * db);
    up = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return {1'b0, sp};
      3'd1: return {1'b0, up};
      3'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = da / db;
        r = da % db;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      3'd4: return {1'b0, h + sp};
      3'd5: return {1'b0, h + up};
      3'd6: return {1'b0, h - sp};
      default: return {1'b0, h - up};
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [31:0] a);
    if (o == DIV || o == DIVU) begin
`ifdef MDU_DIV_EARLY_OUT_EN
      logic [31:0] m;
      int lz;
      m = (o == DIV && a[31]) ? -a : a;
      lz = 32;
      for (int i = 0; i < 32; i++) if (m[i]) lz = 31 - i;
      return (lz == 32) ? 3 : 34 - lz;
`else
      return W + 1;
`endif
    end
    if (o[2]) return S + 2;
    return S + 1;
  endfunction

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, input bit push);
    exp_t e;
    logic [64:0] m;
    op = o; op1 = a; op2 = b; hilo_i = h; start = 1'b1;
    if (push) begin
      m = model(o, a, b, h);
      e.res = m[63:0];
      e.d0  = m[64];
      e.lat = lat_of(o, a);
      e.t0  = cyc;
      e.op  = o;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    // scramble inputs so a design that re-reads them is caught
    op1 = $urandom; op2 = $urandom; hilo_i = {$urandom, $urandom}; op = 3'($urandom);
    if (push) check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] h);
    issue(o, a, b, h, 1'b1);
    wait_idle();
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      check("done_pulse_width", 64'(done_prev), 64'd0);
      check("done_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("div0", 64'(div0), 64'(e.d0));
        check("latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
        last_res = e.res;
        $display("txn op=%0d result=%h div0=%b latency=%0d", e.op, result, div0, cyc - e.t0 - 1);
      end
    end
    done_prev = done;
  end

  initial begin
    int dc, n;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run(MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'd0);
    run(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'd0);
    run(DIVU,  32'h1234_5678, 32'h0000_0000, 64'd0);
    run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    run(MSUBU, 32'd2, 32'd3, 64'd5);
    run(MADD,  32'hFFFF_FFFF, 32'd4, 64'd10);

    // Flush mid-divide: no done, result and div0 untouched
    dc = done_cnt;
    issue(DIV, 32'h7FFF_FFF0, 32'd7, 64'd0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_result", result, last_res);
    check("flush_div0", 64'(div0), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_cnt - dc), 64'd0);

    // Flush together with start in IDLE: start discarded
    op = MULT; op1 = 32'd3; op2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("flush_start_idle", 64'(busy), 64'd0);
    check("flush_start_no_done", 64'(done_cnt - dc), 64'd0);
    check("flush_start_result", result, last_res);

    // Back-to-back start in the done cycle, then an ignored start mid-busy
    dc = done_cnt;
    issue(MULT, 32'd7, 32'd9, 64'd0, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 64'(done), 64'd1);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b1);
    op = DIVU; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("b2b_done_count", 64'(done_cnt - dc), 64'd2);
    check("b2b_div0", 64'(div0), 64'd0);

    // Random mix
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 5) ra = 32'd0;
      run(ro, ra, rb, {$urandom, $urandom});
    end

    // Asynchronous reset mid-operation
    issue(DIVU, 32'hF000_0000, 32'd3, 64'd0, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_div0", 64'(div0), 64'd0);
    check("midrst_result", result, 64'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(MULTU, 32'h0001_0000, 32'h0001_0000, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the EX stage; replaces the fixed-width mul/div helper.
- Supports MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU.
- Explicit start/busy/done handshake, pipelined multiplier of configurable depth, radix-2 restoring divider.
- EX stalls while busy; CP0 flush aborts an operation in flight.

Parameters:
- WIDTH, 32: operand width; result is 2*WIDTH ({hi,lo}).
- MUL_STAGES, 2: register stages in the multiplier array, minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  exception flush; aborts the current operation
- start  in  1  one-cycle request; sampled only while idle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- op1  in  WIDTH  rs operand; dividend for divides
- op2  in  WIDTH  rt operand; divisor for divides
- hilo_i  in  2*WIDTH  current {hi,lo}, used by MADD/MSUB
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when result is valid
- result  out  2*WIDTH  {hi,lo}; for divides hi=remainder, lo=quotient
- div0  out  1  set with done when the divisor was zero

Behaviour:
- Reset: busy=0, done=0, div0=0, result=0, FSM=IDLE, all internal registers cleared.
- Operand, op and hilo_i capture:
  - Captured on the clk edge where start=1, busy=0, flush=0.
  - start while busy=1 is ignored.
  - Inputs are not re-read after capture.
- FSM states: IDLE, MUL, ACC, DIV, FIX.
  - IDLE -> MUL on accepted start when op is 0,1,4-7.
  - IDLE -> DIV on accepted start when op is 2 or 3.
  - MUL -> FIX after MUL_STAGES cycles for op 0/1.
  - MUL -> ACC after MUL_STAGES cycles for op 4-7.
  - ACC -> FIX after 1 cycle.
  - DIV -> FIX after WIDTH iterations, one quotient bit per cycle.
  - FIX -> IDLE: signs applied, result registered, done=1 for exactly one cycle.
- busy is 1 from the cycle after acceptance through the FIX cycle inclusive; done asserts in the cycle busy falls.
- Latency, start edge to done high:
  - MULT/MULTU: MUL_STAGES+1 cycles.
  - MADD-class: MUL_STAGES+2 cycles.
  - DIV/DIVU: WIDTH+1 cycles.
- Back-to-back: start may be asserted in the same cycle done=1; it is accepted.
- Signed ops (MULT, DIV, MADD, MSUB):
  - Operate on magnitudes of op1 and op2.
  - Product and quotient are negated if op1[W-1]^op2[W-1].
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
- Unsigned ops (MULTU, DIVU, MADDU, MSUBU): no sign handling.
- Accumulate: MADD/MADDU give hilo_i + product; MSUB/MSUBU give hilo_i - product. Arithmetic is modulo 2^(2W).
- Signed overflow case MIN/-1: quotient=MIN, remainder=0, div0=0.
- Divide by zero:
  - Divider still runs the full WIDTH iterations.
  - Result: quotient = all ones, remainder = op1 unchanged (no sign fix).
  - div0=1 alongside done.
- div0 holds until the next accepted start.
- result holds its last value until the next FIX cycle.
- flush:
  - In any state, the next edge sets FSM=IDLE, busy=0; no done pulse is produced.
  - result and div0 keep their previous values.
  - flush together with start in IDLE: flush wins, start is discarded.
  - flush in the FIX cycle: done is suppressed and result is not updated.
- Reset mid-operation clears immediately to the reset values.

Optional Feature:
- Macro MDU_DIV_EARLY_OUT_EN.
- Defined:
  - In the first DIV cycle, the divider counts leading zeros of the dividend magnitude.
  - It pre-shifts by that count and runs only WIDTH-lz iterations, minimum 1.
  - Dividend 0 finishes after 1 iteration.
  - Latency is (WIDTH-lz)+2 cycles, variable.
  - Results, div0 and flush behaviour are identical to the undefined case.
- Undefined: fixed WIDTH+1 latency as above; no leading-zero logic is synthesised.

Test Plan:
- MULT op1=0xFFFFFFFE (-2), op2=0x00000003, MUL_STAGES=2 -> done 3 cycles after start, result=0xFFFFFFFF_FFFFFFFA.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> done 33 cycles after start (macro off), lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div0=0.
- DIVU op1=0x12345678, op2=0 -> lo=0xFFFFFFFF, hi=0x12345678, div0=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
- MSUBU hilo_i=0x00000000_00000005, op1=2, op2=3 -> result=0xFFFFFFFF_FFFFFFFF after 4 cycles; MADD hilo_i=10, op1=-1, op2=4 -> result=6.
- DIV started, flush pulsed at cycle 10 -> busy=0 next cycle, no done, result unchanged; second start with flush asserted in the same cycle -> ignored, busy stays 0.
- start asserted in the done cycle with MULTU 0xFFFFFFFF*0xFFFFFFFF -> accepted, result=0xFFFFFFFE_00000001; start at mid-busy -> ignored, no extra done.
